// File: rtl/control_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// control_sequencer_pkg
//   Shared encodings for the multi-cycle AVR control sequencer and every block
//   that consumes its stage / decode buses:
//     STAGE_*   one-hot pipeline stage codes (width STAGE_COUNT)
//     OPCODE_*  bit positions inside the one-hot opcode_type bus
//     GROUP_*   bit positions inside the opcode_group flag bus
//   onehot_opcode()/onehot_group() build single-bit masks from those positions.
// ---------------------------------------------------------------------------
package control_sequencer_pkg;

  localparam int STAGE_COUNT  = 5;
  localparam int OPCODE_COUNT = 11;
  localparam int GROUP_COUNT  = 7;

  typedef enum logic [STAGE_COUNT-1:0] {
    STAGE_IF  = 5'b00001,
    STAGE_ID  = 5'b00010,
    STAGE_EX  = 5'b00100,
    STAGE_MEM = 5'b01000,
    STAGE_WB  = 5'b10000
  } stage_e;

  localparam int OPCODE_ADD  = 0;
  localparam int OPCODE_SUB  = 1;
  localparam int OPCODE_AND  = 2;
  localparam int OPCODE_EOR  = 3;
  localparam int OPCODE_OR   = 4;
  localparam int OPCODE_MOV  = 5;
  localparam int OPCODE_LDI  = 6;
  localparam int OPCODE_LD_X = 7;
  localparam int OPCODE_ST_X = 8;
  localparam int OPCODE_RJMP = 9;
  localparam int OPCODE_BREQ = 10;

  localparam int GROUP_ALU        = 0;
  localparam int GROUP_ALU_TWO_OP = 1;
  localparam int GROUP_IMMEDIATE  = 2;
  localparam int GROUP_MEMORY     = 3;
  localparam int GROUP_LOAD       = 4;
  localparam int GROUP_STORE      = 5;
  localparam int GROUP_BRANCH     = 6;

  function automatic logic [OPCODE_COUNT-1:0] onehot_opcode(input int idx);
    logic [OPCODE_COUNT-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [GROUP_COUNT-1:0] onehot_group(input int idx);
    logic [GROUP_COUNT-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/control_sequencer_decode_unit.sv
// ---------------------------------------------------------------------------
// decode_unit
//   Purely combinational AVR instruction decoder, shared by the sequencer and
//   any other block that needs the same classification.
//   Ports:
//     instruction   in  16            instruction register contents
//     opcode_type   out OPCODE_COUNT  one-hot opcode, zero when unrecognised
//     opcode_group  out GROUP_COUNT   group flags, zero when unrecognised
//   NOP (16'h0000) and any unsupported encoding decode to all-zero.
// ---------------------------------------------------------------------------
module decode_unit
  import control_sequencer_pkg::*;
(
  input  logic [15:0]             instruction,
  output logic [OPCODE_COUNT-1:0] opcode_type,
  output logic [GROUP_COUNT-1:0]  opcode_group
);

  logic [GROUP_COUNT-1:0] w_alu2;

  assign w_alu2 = onehot_group(GROUP_ALU) | onehot_group(GROUP_ALU_TWO_OP);

  always_comb begin
    opcode_type  = '0;
    opcode_group = '0;
    casez (instruction)
      16'b0000_11??_????_????: begin
        opcode_type  = onehot_opcode(OPCODE_ADD);
        opcode_group = w_alu2;
      end
      16'b0001_10??_????_????: begin
        opcode_type  = onehot_opcode(OPCODE_SUB);
        opcode_group = w_alu2;
      end
      16'b0010_00??_????_????: begin
        opcode_type  = onehot_opcode(OPCODE_AND);
        opcode_group = w_alu2;
      end
      16'b0010_01??_????_????: begin
        opcode_type  = onehot_opcode(OPCODE_EOR);
        opcode_group = w_alu2;
      end
      16'b0010_10??_????_????: begin
        opcode_type  = onehot_opcode(OPCODE_OR);
        opcode_group = w_alu2;
      end
      // MOV is a register transfer: two operands but no ALU result flags.
      16'b0010_11??_????_????: begin
        opcode_type  = onehot_opcode(OPCODE_MOV);
        opcode_group = onehot_group(GROUP_ALU_TWO_OP);
      end
      16'b1110_????_????_????: begin
        opcode_type  = onehot_opcode(OPCODE_LDI);
        opcode_group = onehot_group(GROUP_IMMEDIATE);
      end
      16'b1001_000?_????_1100: begin
        opcode_type  = onehot_opcode(OPCODE_LD_X);
        opcode_group = onehot_group(GROUP_MEMORY) | onehot_group(GROUP_LOAD);
      end
      16'b1001_001?_????_1100: begin
        opcode_type  = onehot_opcode(OPCODE_ST_X);
        opcode_group = onehot_group(GROUP_MEMORY) | onehot_group(GROUP_STORE);
      end
      16'b1100_????_????_????: begin
        opcode_type  = onehot_opcode(OPCODE_RJMP);
        opcode_group = onehot_group(GROUP_BRANCH);
      end
      16'b1111_00??_????_?001: begin
        opcode_type  = onehot_opcode(OPCODE_BREQ);
        opcode_group = onehot_group(GROUP_BRANCH);
      end
      default: begin
        opcode_type  = '0;
        opcode_group = '0;
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//   Multi-cycle control sequencer: fetches one instruction word, walks it
//   through IF/ID/EX/MEM/WB, owns the program counter and flags retirement.
//   Optional build macro: SKIP_MEM_STAGE_EN -- when defined, instructions
//   without GROUP_MEMORY go straight from EX to WB.
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     instr_word/valid  fetch data and its qualifier
//     instr_ready       word accepted this cycle (IF and no hold)
//     hold              freezes stage, IR and PC; suppresses retirement
//     branch_taken/target  PC redirect, honoured only in EX
//     pipeline_stage    one-hot current stage
//     instruction       instruction register
//     opcode_type/group decode of the instruction register
//     program_counter   address of the next fetch
//     instr_retired     high in the WB cycle that leaves WB
//
//   state | meaning
//   IF    | waiting for a fetched word
//   ID    | instruction register loaded, decode visible
//   EX    | execute; branch redirect sampled here
//   MEM   | data memory access
//   WB    | write-back; retirement reported when leaving
// ---------------------------------------------------------------------------
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             instr_word,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic                    hold,
  input  logic                    branch_taken,
  input  logic [PC_WIDTH-1:0]     branch_target,
  output logic [STAGE_COUNT-1:0]  pipeline_stage,
  output logic [15:0]             instruction,
  output logic [OPCODE_COUNT-1:0] opcode_type,
  output logic [GROUP_COUNT-1:0]  opcode_group,
  output logic [PC_WIDTH-1:0]     program_counter,
  output logic                    instr_retired
);

  stage_e              r_stage;
  stage_e              w_stage_nxt;
  logic [15:0]         r_instr;
  logic [PC_WIDTH-1:0] r_pc;
  logic                w_accept;
  logic                w_redirect;

  decode_unit u_decode (
    .instruction  (r_instr),
    .opcode_type  (opcode_type),
    .opcode_group (opcode_group)
  );

  always_comb begin
    w_stage_nxt = r_stage;
    w_accept    = 1'b0;
    w_redirect  = 1'b0;
    if (!hold) begin
      unique case (r_stage)
        STAGE_IF: begin
          if (instr_valid) begin
            w_accept    = 1'b1;
            w_stage_nxt = STAGE_ID;
          end
        end
        STAGE_ID: w_stage_nxt = STAGE_EX;
        STAGE_EX: begin
          w_redirect = branch_taken;
`ifdef SKIP_MEM_STAGE_EN
          w_stage_nxt = opcode_group[GROUP_MEMORY] ? STAGE_MEM : STAGE_WB;
`else
          w_stage_nxt = STAGE_MEM;
`endif
        end
        STAGE_MEM: w_stage_nxt = STAGE_WB;
        STAGE_WB:  w_stage_nxt = STAGE_IF;
        default:   w_stage_nxt = STAGE_IF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage <= STAGE_IF;
      r_instr <= 16'h0000;
      r_pc    <= RESET_PC;
    end else begin
      r_stage <= w_stage_nxt;
      if (w_accept) begin
        r_instr <= instr_word;
        r_pc    <= r_pc + PC_WIDTH'(1);
      end else if (w_redirect) begin
        r_pc    <= branch_target;
      end
    end
  end

  assign pipeline_stage  = r_stage;
  assign instruction     = r_instr;
  assign program_counter = r_pc;
  assign instr_ready     = (r_stage == STAGE_IF) && !hold;
  // Retirement must mark the WB cycle that actually leaves WB, so a held WB
  // cycle cannot report it; this makes hold visible here combinationally.
  assign instr_retired   = (r_stage == STAGE_WB) && !hold;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [15:0]             instr_word;
  logic                    instr_valid;
  logic                    instr_ready;
  logic                    hold;
  logic                    branch_taken;
  logic [15:0]             branch_target;
  logic [STAGE_COUNT-1:0]  pipeline_stage;
  logic [15:0]             instruction;
  logic [OPCODE_COUNT-1:0] opcode_type;
  logic [GROUP_COUNT-1:0]  opcode_group;
  logic [15:0]             program_counter;
  logic                    instr_retired;

  always #5 clk = ~clk;

  control_sequencer #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .instr_word      (instr_word),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .hold            (hold),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .pipeline_stage  (pipeline_stage),
    .instruction     (instruction),
    .opcode_type     (opcode_type),
    .opcode_group    (opcode_group),
    .program_counter (program_counter),
    .instr_retired   (instr_retired)
  );

`ifdef SKIP_MEM_STAGE_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: stage index 0..4 = IF,ID,EX,MEM,WB
  int          m_si;
  logic [15:0] m_ir;
  logic [15:0] m_pc;

  logic [STAGE_COUNT-1:0] tr_stage [20];
  logic [15:0]            tr_pc    [20];
  logic [GROUP_COUNT-1:0] tr_grp   [20];
  logic                   tr_ret   [20];

  function automatic logic [STAGE_COUNT-1:0] stage_code(input int si);
    return STAGE_COUNT'(1) << si;
  endfunction

  function automatic bit is_mem(input logic [15:0] w);
    return (w[15:10] == 6'b100100) && (w[3:0] == 4'hC);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] w, input logic h,
                       input logic bt, input logic [15:0] tg, input logic r);
    instr_valid   = v;
    instr_word    = w;
    hold          = h;
    branch_taken  = bt;
    branch_target = tg;
    reset         = r;
    #1;
  endtask

  task automatic model_check();
    check("stage",   32'(pipeline_stage),  32'(stage_code(m_si)));
    check("ready",   32'(instr_ready),     32'((m_si == 0) && !hold));
    check("retired", 32'(instr_retired),   32'((m_si == 4) && !hold));
    check("instr",   32'(instruction),     32'(m_ir));
    check("pc",      32'(program_counter), 32'(m_pc));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_si = 0; m_ir = 16'h0000; m_pc = 16'h0000;
    end else if (!hold) begin
      case (m_si)
        0: if (instr_valid) begin
             m_ir = instr_word; m_pc = m_pc + 16'd1; m_si = 1;
           end
        1: m_si = 2;
        2: begin
             if (branch_taken) m_pc = branch_target;
             m_si = (SKIP && !is_mem(m_ir)) ? 4 : 3;
           end
        3: m_si = 4;
        default: m_si = 0;
      endcase
    end
    #1;
  endtask

  task automatic cyc(input logic v, input logic [15:0] w, input logic h,
                     input logic bt, input logic [15:0] tg, input logic r);
    drive(v, w, h, bt, tg, r);
    model_check();
    tick();
  endtask

  // Runs one instruction from the IF accept cycle (k=0) until back in IF.
  task automatic run_instr(input logic [15:0] w, input logic [19:0] hold_mask,
                           input logic [19:0] bt_mask, input logic [15:0] tg_ex,
                           output int ret_k);
    bit done;
    ret_k = -1;
    done  = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      drive(k == 0, w, hold_mask[k], bt_mask[k], (m_si == 2) ? tg_ex : 16'h1234, 1'b0);
      model_check();
      tr_stage[k] = pipeline_stage;
      tr_pc[k]    = program_counter;
      tr_grp[k]   = opcode_group;
      tr_ret[k]   = instr_retired;
      if (instr_retired && ret_k < 0) ret_k = k;
      tick();
      if (k > 0 && m_si == 0) done = 1;
    end
    check("run_instr_bound", 32'(done), 32'd1);
  endtask

  typedef struct {
    logic [15:0]             w;
    logic [OPCODE_COUNT-1:0] typ;
    logic [GROUP_COUNT-1:0]  grp;
  } dec_vec_t;

  initial begin
    dec_vec_t vec [15];
    logic [GROUP_COUNT-1:0] g_alu2, g_ld, g_st, g_br;
    logic [STAGE_COUNT-1:0] exp_seq [5];
    int rk, alu_ret;
    logic [15:0] words [5];

    g_alu2 = onehot_group(GROUP_ALU) | onehot_group(GROUP_ALU_TWO_OP);
    g_ld   = onehot_group(GROUP_MEMORY) | onehot_group(GROUP_LOAD);
    g_st   = onehot_group(GROUP_MEMORY) | onehot_group(GROUP_STORE);
    g_br   = onehot_group(GROUP_BRANCH);
    vec = '{
      '{16'h0C12, onehot_opcode(OPCODE_ADD),  g_alu2},
      '{16'h1A34, onehot_opcode(OPCODE_SUB),  g_alu2},
      '{16'h2056, onehot_opcode(OPCODE_AND),  g_alu2},
      '{16'h2478, onehot_opcode(OPCODE_EOR),  g_alu2},
      '{16'h2811, onehot_opcode(OPCODE_OR),   g_alu2},
      '{16'h2C01, onehot_opcode(OPCODE_MOV),  onehot_group(GROUP_ALU_TWO_OP)},
      '{16'hEF0F, onehot_opcode(OPCODE_LDI),  onehot_group(GROUP_IMMEDIATE)},
      '{16'h900C, onehot_opcode(OPCODE_LD_X), g_ld},
      '{16'h920C, onehot_opcode(OPCODE_ST_X), g_st},
      '{16'hC005, onehot_opcode(OPCODE_RJMP), g_br},
      '{16'hF009, onehot_opcode(OPCODE_BREQ), g_br},
      '{16'h0000, '0, '0},
      '{16'hFFFF, '0, '0},
      '{16'h900D, '0, '0},
      '{16'hD000, '0, '0}
    };
    alu_ret = SKIP ? 3 : 4;

    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    m_si = 0; m_ir = 16'h0000; m_pc = 16'h0000;

    // reset release, idle for 3 cycles
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
      model_check();
      check("rst_stage", 32'(pipeline_stage), 32'(STAGE_IF));
      check("rst_ready", 32'(instr_ready), 32'd1);
      check("rst_pc", 32'(program_counter), 32'd0);
      check("rst_ret", 32'(instr_retired), 32'd0);
      check("rst_type", 32'(opcode_type), 32'd0);
      check("rst_group", 32'(opcode_group), 32'd0);
      tick();
    end

    // ADD r1,r2: stage sequence, groups from ID, one retire pulse
    exp_seq = '{STAGE_IF, STAGE_ID, STAGE_EX, STAGE_MEM, STAGE_WB};
    if (SKIP) exp_seq[3] = STAGE_WB;
    run_instr(16'h0C12, '0, '0, 16'h0, rk);
    for (int k = 0; k <= alu_ret; k++) begin
      check("add_stage", 32'(tr_stage[k]), 32'(exp_seq[k]));
      check("add_ret", 32'(tr_ret[k]), 32'(k == alu_ret));
      if (k >= 1) check("add_group", 32'(tr_grp[k]), 32'(g_alu2));
    end
    check("add_lat", 32'(rk + 1), SKIP ? 32'd4 : 32'd5);
    check("add_pc", 32'(program_counter), 32'd1);

    // decode table
    foreach (vec[i]) begin
      cyc(1'b1, vec[i].w, 1'b0, 1'b0, 16'h0, 1'b0);
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
      model_check();
      check("dec_type", 32'(opcode_type), 32'(vec[i].typ));
      check("dec_group", 32'(opcode_group), 32'(vec[i].grp));
      tick();
      for (int k = 0; k < 6 && m_si != 0; k++) cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    end

    // LDI with 3 hold cycles in EX
    run_instr(16'hEF0F, 20'b0_0000_0000_0000_0001_1100, '0, 16'h0, rk);
    check("hold_lat", 32'(rk), 32'(alu_ret + 3));
    for (int k = 2; k <= 5; k++) begin
      check("hold_stage", 32'(tr_stage[k]), 32'(STAGE_EX));
      check("hold_pc", 32'(tr_pc[k]), 32'(tr_pc[2]));
    end

    // branch in EX to 0x0040; branch_taken in ID/MEM/WB ignored
    run_instr(16'hC005, 20'b0, 20'b1_1110, 16'h0040, rk);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    check("br_pc", 32'(program_counter), 32'h0040);
    tick();
    run_instr(16'h0C12, '0, '0, 16'h0, rk);
    check("br_fetch_pc", 32'(tr_pc[1]), 32'h0041);

    // branch to 0xFFFF, next fetch wraps the PC to 0
    run_instr(16'hF009, 20'b0, 20'b100, 16'hFFFF, rk);
    run_instr(16'h2811, '0, '0, 16'h0, rk);
    check("wrap_pc", 32'(tr_pc[1]), 32'h0000);

    // LD always visits MEM
    run_instr(16'h900C, '0, '0, 16'h0, rk);
    check("ld_lat", 32'(rk + 1), 32'd5);
    check("ld_mem", 32'(tr_stage[3]), 32'(STAGE_MEM));

    // reset while in MEM
    for (int k = 0; k < 3; k++) cyc(k == 0, 16'h900C, 1'b0, 1'b0, 16'h0, 1'b0);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    check("mrst_in_mem", 32'(pipeline_stage), 32'(STAGE_MEM));
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
      check("mrst_stage", 32'(pipeline_stage), 32'(STAGE_IF));
      check("mrst_instr", 32'(instruction), 32'h0);
      check("mrst_pc", 32'(program_counter), 32'h0);
      check("mrst_ret", 32'(instr_retired), 32'h0);
      model_check();
      tick();
    end

    // randomized traffic against the model
    words = '{16'h0C12, 16'hEF0F, 16'h900C, 16'h920C, 16'h0000};
    for (int i = 0; i < 600; i++) begin
      logic [15:0] w;
      w = ($urandom_range(0, 5) == 5) ? 16'($urandom) : words[$urandom_range(0, 4)];
      cyc($urandom_range(0, 9) < 6, w, $urandom_range(0, 9) < 2,
          $urandom_range(0, 9) < 3, 16'($urandom), $urandom_range(0, 99) < 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
